// File: rtl/pulse_sync_mc_pkg.sv
// Shared constants and helpers for the multi-channel pulse synchroniser.
package pulse_sync_mc_pkg;

   localparam int PSM_MIN_STAGES = 2;

   // Width of a counter that must hold values 0..filt_len.
   function automatic int psm_cnt_w(input int filt_len);
      return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
   endfunction

endpackage

// File: rtl/psm_chain.sv
// One channel of synchroniser flops (s[1]..s[STAGES-1]); the final dout flop
// lives in the top because the optional glitch filter sits in front of it.
module psm_chain
   import pulse_sync_mc_pkg::*;
#(
   parameter int   DEPTH   = 1,
   parameter logic RST_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst_,
   input  logic en_i,
   input  logic din_i,
   output logic q_o
);

   logic [DEPTH-1:0] s_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         s_q <= {DEPTH{RST_BIT}};
      end else if (en_i) begin
         s_q[0] <= din_i;
         for (int i = 1; i < DEPTH; i++) begin
            s_q[i] <= s_q[i-1];
         end
      end
   end

   assign q_o = s_q[DEPTH-1];

endmodule

// File: rtl/pulse_sync_mc.sv
// CH-channel synchroniser with level, rise/fall pulses and sticky event flags.
// Define PULSE_SYNC_MC_FILTER_EN to add a FILT_LEN-cycle glitch filter before dout.
module pulse_sync_mc
   import pulse_sync_mc_pkg::*;
#(
   parameter int            CH       = 4,
   parameter int            STAGES   = 2,
   parameter logic [CH-1:0] RST_VAL  = {CH{1'b0}},
   parameter int            FILT_LEN = 4
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic          en,
   input  logic [CH-1:0] din,
   input  logic [CH-1:0] clr_evt,
   output logic [CH-1:0] dout,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic [CH-1:0] evt,
   output logic          any_evt
);

   if (STAGES < PSM_MIN_STAGES) begin : g_bad_stages
      $error("pulse_sync_mc: STAGES must be at least %0d", PSM_MIN_STAGES);
   end
   if (FILT_LEN < 1) begin : g_bad_filt
      $error("pulse_sync_mc: FILT_LEN must be at least 1");
   end

   logic [CH-1:0] sync_lvl;
   logic [CH-1:0] dout_q, dout_d;
   logic [CH-1:0] rise_q, rise_d, fall_q, fall_d;
   logic [CH-1:0] evt_q, evt_d;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      psm_chain #(
         .DEPTH   (STAGES - 1),
         .RST_BIT (RST_VAL[i])
      ) u_chain (
         .clk   (clk),
         .rst_  (rst_),
         .en_i  (en),
         .din_i (din[i]),
         .q_o   (sync_lvl[i])
      );
   end

`ifdef PULSE_SYNC_MC_FILTER_EN
   localparam int CW = psm_cnt_w(FILT_LEN);

   logic [CW-1:0] cnt_q [CH];
   logic [CW-1:0] cnt_d [CH];

   // The counter holds FILT_LEN disagreeing edges; the next disagreeing edge commits.
   // NOTE: every always_comb output gets a default first, so no path infers a latch.
   always_comb begin
      dout_d = dout_q;
      for (int i = 0; i < CH; i++) begin
         cnt_d[i] = '0;
         if (sync_lvl[i] != dout_q[i]) begin
            if (cnt_q[i] == CW'(FILT_LEN)) begin
               dout_d[i] = sync_lvl[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
      end else if (en) begin
         for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end
`else
   assign dout_d = sync_lvl;
`endif

   assign rise_d = dout_d & ~dout_q;
   assign fall_d = ~dout_d & dout_q;
   // A set in the same edge as a clear wins.
   assign evt_d  = (evt_q & ~clr_evt) | rise_d | fall_d;

   // Pulse flops clear on disabled edges so a masked pulse never reappears.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         dout_q <= RST_VAL;
         rise_q <= '0;
         fall_q <= '0;
         evt_q  <= '0;
      end else if (en) begin
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         evt_q  <= evt_d;
      end else begin
         rise_q <= '0;
         fall_q <= '0;
      end
   end

   assign dout    = dout_q;
   assign rise    = rise_q & {CH{en}};
   assign fall    = fall_q & {CH{en}};
   assign evt     = evt_q;
   assign any_evt = |evt_q;

endmodule

// File: tb/tb_pulse_sync_mc.sv
// Self-checking bench: three pulse_sync_mc instances against a delay-line model.
module tb_pulse_sync_mc;

   localparam int F = 4;
`ifdef PULSE_SYNC_MC_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif
   localparam int         STG [3] = '{2, 3, 2};
   localparam logic [3:0] RV  [3] = '{4'h0, 4'h0, 4'hA};

   logic       clk  = 1'b0;
   logic       rst_ = 1'b0;
   logic       en   = 1'b1;
   logic [3:0] din  [3];
   logic [3:0] clr  [3];
   logic [3:0] dout [3];
   logic [3:0] rise [3];
   logic [3:0] fall [3];
   logic [3:0] evt  [3];
   logic       any_evt [3];

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   pulse_sync_mc #(.CH(4), .STAGES(2), .RST_VAL(4'h0), .FILT_LEN(F)) u_a (
      .clk(clk), .rst_(rst_), .en(en), .din(din[0]), .clr_evt(clr[0]),
      .dout(dout[0]), .rise(rise[0]), .fall(fall[0]), .evt(evt[0]), .any_evt(any_evt[0]));
   pulse_sync_mc #(.CH(4), .STAGES(3), .RST_VAL(4'h0), .FILT_LEN(F)) u_b (
      .clk(clk), .rst_(rst_), .en(en), .din(din[1]), .clr_evt(clr[1]),
      .dout(dout[1]), .rise(rise[1]), .fall(fall[1]), .evt(evt[1]), .any_evt(any_evt[1]));
   pulse_sync_mc #(.CH(4), .STAGES(2), .RST_VAL(4'hA), .FILT_LEN(F)) u_c (
      .clk(clk), .rst_(rst_), .en(en), .din(din[2]), .clr_evt(clr[2]),
      .dout(dout[2]), .rise(rise[2]), .fall(fall[2]), .evt(evt[2]), .any_evt(any_evt[2]));

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model: dout is din delayed by STAGES enabled edges ----------------
   logic       s_en, s_ok;
   logic [3:0] s_din [3];
   logic [3:0] s_clr [3];
   logic [3:0] m_hist [3][8];
   logic [3:0] m_dout [3];
   logic [3:0] m_rise [3];
   logic [3:0] m_fall [3];
   logic [3:0] m_evt  [3];
   int         m_run  [3][4];

   task automatic model_reset();
      for (int m = 0; m < 3; m++) begin
         for (int j = 0; j < 8; j++) m_hist[m][j] = RV[m];
         m_dout[m] = RV[m];
         m_rise[m] = '0;
         m_fall[m] = '0;
         m_evt[m]  = '0;
         for (int b = 0; b < 4; b++) m_run[m][b] = 0;
      end
   endtask

   task automatic model_step();
      logic [3:0] lvl, nd;
      for (int m = 0; m < 3; m++) begin
         if (!s_en) begin
            m_rise[m] = '0;
            m_fall[m] = '0;
         end else begin
            for (int j = 7; j > 0; j--) m_hist[m][j] = m_hist[m][j-1];
            m_hist[m][0] = s_din[m];
            lvl = m_hist[m][STG[m]-1];
            nd  = m_dout[m];
            if (!FILT) begin
               nd = lvl;
            end else begin
               // A new level must disagree with dout on FILT_LEN+1 consecutive edges.
               for (int b = 0; b < 4; b++) begin
                  if (lvl[b] != nd[b]) begin
                     m_run[m][b]++;
                     if (m_run[m][b] == F + 1) begin
                        nd[b] = lvl[b];
                        m_run[m][b] = 0;
                     end
                  end else begin
                     m_run[m][b] = 0;
                  end
               end
            end
            m_rise[m] = nd & ~m_dout[m];
            m_fall[m] = ~nd & m_dout[m];
            m_evt[m]  = (m_evt[m] & ~s_clr[m]) | m_rise[m] | m_fall[m];
            m_dout[m] = nd;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      s_en  = en;
      s_ok  = rst_;
      s_din = din;
      s_clr = clr;
   end

   initial forever begin
      @(negedge clk);
      if (!rst_)     model_reset();
      else if (s_ok) model_step();
      for (int m = 0; m < 3; m++) begin
         check($sformatf("model dout[%0d]", m), dout[m], m_dout[m]);
         check($sformatf("model rise[%0d]", m), rise[m], en ? m_rise[m] : 4'h0);
         check($sformatf("model fall[%0d]", m), fall[m], en ? m_fall[m] : 4'h0);
         check($sformatf("model evt[%0d]", m),  evt[m],  m_evt[m]);
         check($sformatf("model any_evt[%0d]", m), {3'b000, any_evt[m]}, {3'b000, |m_evt[m]});
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      din = '{4'h0, 4'h0, 4'hA};
      clr = '{4'h0, 4'h0, 4'h0};
      cyc(3);
      check("reset dout_c", dout[2], 4'hA);
      check("reset evt_a",  evt[0],  4'h0);
      rst_ = 1'b1;
`ifndef PULSE_SYNC_MC_FILTER_EN
      din[0] = 4'b0001;
      din[1] = 4'b0001;
      cyc(1);
      check("lat a after 1 edge", dout[0], 4'b0000);
      cyc(1);
      check("lat a dout", dout[0], 4'b0001);
      check("lat a rise", rise[0], 4'b0001);
      check("lat a evt",  evt[0],  4'b0001);
      check("lat a any",  {3'b000, any_evt[0]}, 4'b0001);
      cyc(1);
      check("lat a rise once", rise[0], 4'b0000);
      check("b rise stg3", rise[1], 4'b0001);
      clr[0] = 4'hF;
      clr[1] = 4'hF;
      cyc(1);
      clr[0] = 4'h0;
      clr[1] = 4'h0;
      check("b evt cleared", evt[1], 4'b0000);
      din[1] = 4'b0000;
      cyc(2);
      clr[1] = 4'b0001;
      cyc(1);
      check("b fall", fall[1], 4'b0001);
      check("b set wins", evt[1], 4'b0001);
      cyc(1);
      check("b clear next", evt[1], 4'b0000);
      check("b fall once", fall[1], 4'b0000);
      clr[1] = 4'h0;
      din[0] = 4'b0101;
      cyc(1);
      en = 1'b0;
      cyc(1);
      check("hold rise", rise[0], 4'b0000);
      cyc(4);
      check("hold dout", dout[0], 4'b0001);
      en = 1'b1;
      cyc(1);
      check("re-en dout", dout[0], 4'b0101);
      check("re-en rise", rise[0], 4'b0100);
      cyc(1);
      check("re-en rise once", rise[0], 4'b0000);
      check("c no pulse evt", evt[2], 4'b0000);
      din[2] = 4'b0101;
      cyc(1);
      rst_   = 1'b0;
      din[0] = 4'b1000;
      #1;
      check("async dout_c", dout[2], 4'hA);
      check("async rise_c", rise[2], 4'h0);
      check("async fall_c", fall[2], 4'h0);
      check("async evt_c",  evt[2],  4'h0);
      check("async evt_a",  evt[0],  4'h0);
      cyc(2);
      rst_ = 1'b1;
      cyc(3);
      clr = '{4'hF, 4'hF, 4'hF};
      cyc(1);
      clr = '{4'h0, 4'h0, 4'h0};
      check("indep pre evt", evt[0], 4'b0000);
      din[0] = 4'b0001;
      cyc(2);
      check("indep rise", rise[0], 4'b0001);
      check("indep fall", fall[0], 4'b1000);
      check("indep evt",  evt[0],  4'b1001);
      cyc(3);
`else
      din[0] = 4'b0010;
      cyc(3);
      din[0] = 4'b0000;
      cyc(5);
      check("glitch dout", dout[0], 4'b0000);
      check("glitch evt",  evt[0],  4'b0000);
      din[0] = 4'b0010;
      cyc(5);
      check("filt edge5 dout", dout[0], 4'b0000);
      cyc(1);
      check("filt edge6 dout", dout[0], 4'b0010);
      check("filt edge6 rise", rise[0], 4'b0010);
      din[0] = 4'b0000;
      cyc(1);
      check("filt rise once", rise[0], 4'b0000);
      cyc(12);
      check("filt fall done", dout[0], 4'b0000);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
